approx_mul_pipe: RTL and testbench

//  Parametrised, 3-stage pipelined unsigned multiplier with a runtime mode select.
//  The approximate mode uses a dynamic-segment scheme: a SEG-bit window starts at each

---
 rtl/approx_mul_pkg.sv | 17 +
 rtl/approx_mul_lod_segment.sv | 29 ++
 rtl/approx_mul_pipe.sv | 115 +++++++++++
 tb/tb_approx_mul_pipe.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/approx_mul_pkg.sv
// Shared definitions for the approximate/exact pipelined multiplier.
//   MODE_APPROX / MODE_EXACT : encoding of the per-item mode bit
//   clog2                    : width helper for the segment shift amount
package approx_mul_pkg;

    localparam logic MODE_APPROX = 1'b0;
    localparam logic MODE_EXACT  = 1'b1;

    // Never returns 0 so a shift field stays at least 1 bit wide even when SEG == WIDTH.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/approx_mul_lod_segment.sv
// lod_segment: leading-one detect plus SEG-bit window extraction for one operand.
//   x_i   : operand (WIDTH bits, unsigned)
//   seg_o : SEG-bit window starting at the leading one, LSB forced to 1;
//           equals x_i when x_i < 2^SEG
//   sh_o  : left shift that restores the window to its original weight
module lod_segment #(
    parameter int WIDTH = 16,
    parameter int SEG   = 8,
    parameter int SHW   = 4
) (
    input  logic [WIDTH-1:0] x_i,
    output logic [SEG-1:0]   seg_o,
    output logic [SHW-1:0]   sh_o
);

    always_comb begin
        sh_o  = '0;
        seg_o = x_i[SEG-1:0];
        // Last match wins, so sh_o ends at the highest set bit at or above SEG.
        for (int i = SEG; i < WIDTH; i++) begin
            if (x_i[i]) sh_o = SHW'(i - SEG + 1);
        end
        // sh_o is nonzero exactly when x_i >= 2^SEG.
        if (sh_o != '0) begin
            seg_o = SEG'(x_i >> sh_o) | SEG'(1);
        end
    end

endmodule

// File: rtl/approx_mul_pipe.sv
// approx_mul_pipe: 3-stage pipelined unsigned multiplier, per-item exact/approx mode.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake; in_mode, in0, in1 are the item
//   out_valid/out_ready : output handshake; out is the product, out_mode its mode
// Stage 1 segments operands, stage 2 multiplies, stage 3 scales.
// A single global enable freezes every stage whenever the output is stalled.
module approx_mul_pipe
    import approx_mul_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [WIDTH-1:0]   in0,
    input  logic [WIDTH-1:0]   in1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               out_mode
);

    localparam int SHW = clog2(WIDTH - SEG + 1);

    logic [3:1]         vld_q;
    logic               adv;

    logic [SEG-1:0]     seg_a, seg_b;
    logic [SHW-1:0]     sh_a, sh_b;

    logic [WIDTH-1:0]   s1_a_q, s1_b_q, s1_a_d, s1_b_d;
    logic [SHW-1:0]     s1_sha_q, s1_shb_q, s1_sha_d, s1_shb_d;
    logic               s1_mode_q;

    logic [2*WIDTH-1:0] s2_m_q, s2_m_d;
    logic [SHW:0]       s2_sh_q, s2_sh_d;
    logic               s2_mode_q;

    logic [2*WIDTH-1:0] out_q, out_d;
    logic               out_mode_q;

    assign adv       = !vld_q[3] || out_ready;
    // Held high during reset so upstream never sees backpressure from stale state.
    assign in_ready  = adv || rst;
    assign out_valid = vld_q[3];
    assign out       = out_q;
    assign out_mode  = out_mode_q;

    lod_segment #(.WIDTH(WIDTH), .SEG(SEG), .SHW(SHW)) u_lod_a (
        .x_i(in0), .seg_o(seg_a), .sh_o(sh_a)
    );
    lod_segment #(.WIDTH(WIDTH), .SEG(SEG), .SHW(SHW)) u_lod_b (
        .x_i(in1), .seg_o(seg_b), .sh_o(sh_b)
    );

    // Approx segments are zero-extended into the operand registers, so one
    // WIDTH x WIDTH multiplier serves both modes: segA*segB fits unchanged.
    always_comb begin
        s1_a_d   = in0;
        s1_b_d   = in1;
        s1_sha_d = '0;
        s1_shb_d = '0;
        if (in_mode == MODE_APPROX) begin
            s1_a_d   = WIDTH'(seg_a);
            s1_b_d   = WIDTH'(seg_b);
            s1_sha_d = sh_a;
            s1_shb_d = sh_b;
        end
    end

    assign s2_m_d  = (2*WIDTH)'(s1_a_q) * (2*WIDTH)'(s1_b_q);
    assign s2_sh_d = (SHW+1)'(s1_sha_q) + (SHW+1)'(s1_shb_q);
    // Exact items carry a zero shift, so the scale stage is mode-agnostic.
    assign out_d   = s2_m_q << s2_sh_q;

    // Data registers load only behind a valid item, so bubbles leave the
    // last product on out instead of junk.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_sha_q   <= '0;
            s1_shb_q   <= '0;
            s1_mode_q  <= MODE_APPROX;
            s2_m_q     <= '0;
            s2_sh_q    <= '0;
            s2_mode_q  <= MODE_APPROX;
            out_q      <= '0;
            out_mode_q <= MODE_APPROX;
        end else if (adv) begin
            vld_q <= {vld_q[2:1], in_valid};
            if (in_valid) begin
                s1_a_q    <= s1_a_d;
                s1_b_q    <= s1_b_d;
                s1_sha_q  <= s1_sha_d;
                s1_shb_q  <= s1_shb_d;
                s1_mode_q <= in_mode;
            end
            if (vld_q[1]) begin
                s2_m_q    <= s2_m_d;
                s2_sh_q   <= s2_sh_d;
                s2_mode_q <= s1_mode_q;
            end
            if (vld_q[2]) begin
                out_q      <= out_d;
                out_mode_q <= s2_mode_q;
            end
        end
    end

endmodule

// File: tb/tb_approx_mul_pipe.sv
module tb_approx_mul_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_mode;
    logic [15:0] in0, in1;
    logic        out_valid, out_ready, out_mode;
    logic [31:0] out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    approx_mul_pipe #(.WIDTH(16), .SEG(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in0(in0), .in1(in1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_mode(out_mode)
    );

    typedef struct {
        logic        mode;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: shift the operand down until it fits in 8 bits, then force the LSB.
    function automatic logic [31:0] ref_mul(input logic mode, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] sa, sb;
        int          na, nb;
        if (mode) return 32'(a) * 32'(b);
        na = 0; nb = 0;
        sa = a; sb = b;
        while (sa >= 16'd256) begin sa = sa >> 1; na++; end
        while (sb >= 16'd256) begin sb = sb >> 1; nb++; end
        if (na > 0) sa = sa | 16'd1;
        if (nb > 0) sb = sb | 16'd1;
        return (32'(sa) * 32'(sb)) << (na + nb);
    endfunction

    // Send one item, wait for its result, check value, mode and latency.
    task automatic run_one(input vec_t v);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1; in_mode = v.mode; in0 = v.a; in1 = v.b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (out_valid || lat > 20) break;
            @(posedge clk);
            lat++;
        end
        check({v.name, " value"}, out, v.exp);
        check({v.name, " mode"}, 32'(out_mode), 32'(v.mode));
        check({v.name, " latency"}, lat, 3);
    endtask

    initial begin
        logic [15:0] lfsr;
        logic [31:0] expq[$];
        logic [31:0] prev_out;
        logic        prev_stall;
        int          sent, recv, cyc;

        vecs[0] = '{1'b0, 16'd1024,  16'd2134,  32'd2196096,    "approx 1024x2134"};
        vecs[1] = '{1'b1, 16'd1024,  16'd2134,  32'd2185216,    "exact 1024x2134"};
        vecs[2] = '{1'b0, 16'd200,   16'd255,   32'd51000,      "approx 200x255"};
        vecs[3] = '{1'b0, 16'd0,     16'd65535, 32'd0,          "approx 0x65535"};
        vecs[4] = '{1'b0, 16'd65535, 16'd65535, 32'd4261478400, "approx max"};
        vecs[5] = '{1'b1, 16'd65535, 16'd65535, 32'd4294836225, "exact max"};

        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in0 = '0; in1 = '0; out_ready = 1'b1;
        @(negedge clk);
        check("in_ready during reset", 32'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", 32'(out_valid), 0);
        check("reset out", out, 0);
        check("reset out_mode", 32'(out_mode), 0);
        check("reset in_ready", 32'(in_ready), 1);

        for (int i = 0; i < 6; i++) run_one(vecs[i]);

        // Back to back approx max then exact max: consecutive outputs, modes 0 then 1.
        @(posedge clk); #1;
        in_valid = 1'b1; in_mode = 1'b0; in0 = 16'hFFFF; in1 = 16'hFFFF;
        @(posedge clk); #1;
        in_mode = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b early valid", 32'(out_valid), 0);
        @(posedge clk); @(negedge clk);
        check("b2b first valid", 32'(out_valid), 1);
        check("b2b first value", out, 32'd4261478400);
        check("b2b first mode", 32'(out_mode), 0);
        @(posedge clk); @(negedge clk);
        check("b2b second valid", 32'(out_valid), 1);
        check("b2b second value", out, 32'd4294836225);
        check("b2b second mode", 32'(out_mode), 1);
        @(posedge clk); @(negedge clk);
        check("b2b drained", 32'(out_valid), 0);

        // Streaming with pseudo-random backpressure.
        lfsr = 16'hACE1; sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; prev_out = '0;
        while (recv < 40 && cyc < 800) begin
            @(posedge clk); #1;
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            out_ready = lfsr[0] | lfsr[3];
            in_valid  = (sent < 40);
            in_mode   = sent[0];
            in0       = 16'(1024 + sent);
            in1       = 16'd2134;
            @(negedge clk);
            check("stream in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (prev_stall) begin
                check("stream stall valid", 32'(out_valid), 1);
                check("stream stall stable", out, prev_out);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) check("stream extra output", 32'(out_valid), 0);
                else check($sformatf("stream item %0d", recv), out, expq.pop_front());
                recv++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(ref_mul(in_mode, in0, in1));
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = out;
            cyc++;
        end
        #1 in_valid = 1'b0; out_ready = 1'b1;
        check("stream received count", recv, 40);
        check("stream leftover", expq.size(), 0);

        // Reset with three items in flight and output stalled.
        @(posedge clk); #1;
        in_valid = 1'b1; in_mode = 1'b1; in0 = 16'd7; in1 = 16'd9;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("mid reset in_ready", 32'(in_ready), 1);
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("post reset out_valid", 32'(out_valid), 0);
        check("post reset out", out, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("no stale item %0d", i), 32'(out_valid), 0);
        end
        run_one('{1'b0, 16'd300, 16'd5, ref_mul(1'b0, 16'd300, 16'd5), "after reset"});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
